dram_controller: RTL and testbench
==================================

Name:
dram_controller

Overview:
- Single-clock DRAM controller placed between an L2 cache request port and a bit-serial DRAM bank model (dram_bfm: 8 banks × 128 rows × 8 cols, 1-bit data).
- Captures L2 requests into an internal FIFO and decodes each 20-bit request word into bank, row and column fields.
- Serialises each 8-bit L2 word into 8 one-bit DRAM accesses, each carried by a four-phase cmd_req/cmd_ack handshake.
- Inserts periodic refresh commands.

Parameters:
- L2_REQ_WIDTH, 20: L2 request word width.
- DATA_WIDTH, 8: L2 data width; also the number of DRAM bit accesses per request.
- NUM_OF_BANKS, 8: number of banks; width of the one-hot bank_sel.
- NUM_OF_ROWS, 128: rows per bank; width of the one-hot row_sel.
- NUM_OF_COLS, 8: columns per row; width of the one-hot col_sel.
- CONCAT_ADDRESS, 20: width of the FIFO address payload; must equal L2_REQ_WIDTH.
- FIFO_DEPTH, 16: request FIFO entries.
- REFRESH_INTERVAL, 512: clock cycles between refresh requests.

Ports:
- clk, in, 1: clock; all logic on rising edge.
- rst_b, in, 1: reset; synchronous, active-high (1 = reset).
- l2_rw_req, in, 1: request direction; 1 = write, 0 = read.
- l2_req_instr, in, L2_REQ_WIDTH: request word. Fields: [19:13] offset, [12:10] bank_id, [9:3] row_id, [2:0] col_id.
- l2_req_data, in, DATA_WIDTH: write data.
- cmd_ack, in, 1: DRAM handshake acknowledge.
- cmd_req, out, 1: DRAM command request.
- cmd, out, 2: command code. 00 ACT, 01 READ, 10 WRITE, 11 REFRESH.
- bank_sel, out, NUM_OF_BANKS: one-hot bank select.
- row_sel, out, NUM_OF_ROWS: one-hot row select.
- col_sel, out, NUM_OF_COLS: one-hot column select.
- bank_rw, out, 1: 1 = write the bank cell, 0 = read it.
- buf_rw, out, 1: 1 = controller drives dram_data; 0 = controller tri-states it.
- dram_data, inout, 1: serial DRAM data bit.
- l2_rsp_data, out, DATA_WIDTH: assembled read data.

Behaviour:
- Reset values:
  - cmd_req=0, cmd=00, all selects 0, bank_rw=0, buf_rw=0, l2_rsp_data=0, dram_data=Z.
  - FIFO empty; refresh counter=0; refresh_flag=0; FSM in IDLE.
- Request capture:
  - The tuple {l2_rw_req, l2_req_instr, l2_req_data} is registered every cycle.
  - A new request is one whose {l2_rw_req, l2_req_instr} differs from the previous cycle's tuple; the first cycle after reset counts as new.
  - A new request is pushed into the FIFO if the FIFO is not full; if full, it is silently dropped.
  - Simultaneous push and pop are both allowed. FIFO pointers wrap modulo FIFO_DEPTH.
- Decode:
  - Internal bank_id/row_id/col_id/offset are taken from the FIFO head.
  - Offset is carried through but does not affect addressing.
  - Each select output is the one-hot of its field.
  - Bit i of a request targets column (col_id + i) mod NUM_OF_COLS.
- Handshake (four-phase, cmd_ack sampled on clk):
  - Assert cmd_req with cmd/selects/data stable.
  - Hold until cmd_ack is sampled 1, then drop cmd_req the next cycle.
  - Wait until cmd_ack is sampled 0 before starting the next command.
- FSM states:
  - IDLE:
    - If refresh_flag=1, go to REF. Refresh has priority over the FIFO.
    - Else if the FIFO is not empty, pop it and go to ACT.
  - ACT: issue cmd 00 with bank_sel/row_sel; load access_count = DATA_WIDTH-1; go to XFER.
  - XFER, write request: cmd 10, bank_rw=1, buf_rw=1, dram_data = data[DATA_WIDTH-1-access_count].
  - XFER, read request: cmd 01, bank_rw=0, buf_rw=0; dram_data is sampled into l2_rsp_data[DATA_WIDTH-1-access_count] on the ack-high cycle.
  - XFER, per bit: after each completed handshake, if access_count==0 go to IDLE, else decrement and repeat.
  - REF: issue cmd 11 with bank_sel all ones; clear refresh_flag on handshake completion; go to IDLE.
- Refresh:
  - The counter increments every cycle.
  - At REFRESH_INTERVAL-1 it wraps to 0 and sets refresh_flag.
  - refresh_flag holds until serviced; a request already in progress completes first.
- Read data: l2_rsp_data keeps its last value between reads; bits are written in place during a read.
- buf_rw=0 is the default outside write XFER.
- rst_b asserted mid-handshake: all outputs return to reset values on the next edge and the FIFO is flushed.

Decomposition:
- Package dram_ctrl_pkg:
  - cmd codes (CMD_ACT/READ/WRITE/REF);
  - request field LSB/MSB constants;
  - FSM state enum.
- Sub-module dram_req_fifo: parameterised synchronous FIFO carrying {rw, instr, data}, with full/empty flags.
- Address decode, FSM and refresh counter stay in the top module.

Test Plan:
- Reset: hold rst_b=1 for 2 cycles -> cmd_req=0, all selects 0, buf_rw=0, dram_data=Z, l2_rsp_data=0.
- Single write, l2_rw_req=1, instr bank3/row5/col2, data 0xA5:
  - cmd 00 first with bank_sel=0x08 and row_sel bit5 set;
  - then 8 WRITE handshakes at cols 2,3,…,7,0,1 carrying bits 1,0,1,0,0,1,0,1;
  - the model holds those bits.
- Read-back of the same address with l2_rw_req=0 -> 8 READ handshakes; l2_rsp_data=0xA5 after the last ack.
- Refresh: idle for REFRESH_INTERVAL cycles -> refresh_flag rises, one cmd 11 handshake with bank_sel=0xFF, refresh_flag clears.
- Overflow: 32 distinct write requests on consecutive cycles -> first 16 accepted and executed in order; the rest dropped; FIFO never exceeds 16 entries.
- Reset mid-XFER (after 3 bits) -> outputs at reset values next cycle; no further commands until a new request arrives.

Source files
------------

// File: rtl/dram_ctrl_pkg.sv
// Shared constants, command codes, request field positions and FSM state for the DRAM controller.
package dram_ctrl_pkg;
    localparam int L2_REQ_WIDTH     = 20;
    localparam int DATA_WIDTH       = 8;
    localparam int NUM_OF_BANKS     = 8;
    localparam int NUM_OF_ROWS      = 128;
    localparam int NUM_OF_COLS      = 8;
    localparam int CONCAT_ADDRESS   = 20;
    localparam int FIFO_DEPTH       = 16;
    localparam int REFRESH_INTERVAL = 512;
    localparam int FIFO_CNT_W       = $clog2(FIFO_DEPTH) + 1;

    localparam logic [1:0] CMD_ACT   = 2'b00;
    localparam logic [1:0] CMD_READ  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_REF   = 2'b11;

    localparam int COL_LSB  = 0;
    localparam int COL_MSB  = 2;
    localparam int ROW_LSB  = 3;
    localparam int ROW_MSB  = 9;
    localparam int BANK_LSB = 10;
    localparam int BANK_MSB = 12;
    localparam int OFS_LSB  = 13;
    localparam int OFS_MSB  = 19;

    // *_REL states hold cmd_req low until cmd_ack has been seen low again.
    typedef enum logic [2:0] {
        ST_IDLE, ST_ACT, ST_ACT_REL, ST_XFER, ST_XFER_REL, ST_REF, ST_REF_REL
    } state_t;

    typedef struct packed {
        state_t                        state;
        logic                          refresh_flag;
        logic [FIFO_CNT_W-1:0]         fifo_count;
        logic [OFS_MSB-OFS_LSB:0]      offset;
    } dbg_t;
endpackage

// File: rtl/dram_req_fifo.sv
// Synchronous request FIFO with full/empty flags; pushes while full are discarded.
module dram_req_fifo #(
    parameter int WIDTH = 29,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst_b) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/dram_controller.sv
// L2-to-DRAM controller: queues requests, serialises each data word into per-bit
// four-phase cmd_req/cmd_ack accesses and inserts periodic refresh.
module dram_controller
    import dram_ctrl_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     l2_rw_req,
    input  logic [L2_REQ_WIDTH-1:0]  l2_req_instr,
    input  logic [DATA_WIDTH-1:0]    l2_req_data,
    input  logic                     cmd_ack,
    output logic                     cmd_req,
    output logic [1:0]               cmd,
    output logic [NUM_OF_BANKS-1:0]  bank_sel,
    output logic [NUM_OF_ROWS-1:0]   row_sel,
    output logic [NUM_OF_COLS-1:0]   col_sel,
    output logic                     bank_rw,
    output logic                     buf_rw,
    inout  wire                      dram_data,
    output logic [DATA_WIDTH-1:0]    l2_rsp_data,
    output dbg_t                     dbg
);
    localparam int KEY_W = 1 + L2_REQ_WIDTH;
    localparam int REQ_W = KEY_W + DATA_WIDTH;
    localparam int CNT_W = $clog2(REFRESH_INTERVAL);
    localparam int BIT_W = $clog2(DATA_WIDTH);

    logic [KEY_W-1:0]          prev_key;
    logic                      first_q;
    logic                      new_req;
    logic [REQ_W-1:0]          head;
    logic [REQ_W-1:0]          cur;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      fifo_pop;
    logic [FIFO_CNT_W-1:0]     fifo_count;
    state_t                    state_q;
    state_t                    state_d;
    logic [BIT_W-1:0]          access_count;
    logic [BIT_W-1:0]          bit_idx;
    logic [CNT_W-1:0]          refresh_cnt;
    logic                      refresh_flag;
    logic                      ref_done;

    logic                      cur_rw;
    logic [L2_REQ_WIDTH-1:0]   cur_instr;
    logic [DATA_WIDTH-1:0]     cur_data;
    logic [BANK_MSB-BANK_LSB:0] bank_id;
    logic [ROW_MSB-ROW_LSB:0]  row_id;
    logic [COL_MSB-COL_LSB:0]  col_id;
    logic [COL_MSB-COL_LSB:0]  col_idx;

    // Only address/direction changes mark a new request; data alone does not.
    assign new_req = first_q || ({l2_rw_req, l2_req_instr} != prev_key);

    dram_req_fifo #(.WIDTH(REQ_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_b (rst_b),
        .push  (new_req && !fifo_full),
        .pop   (fifo_pop),
        .wdata ({l2_rw_req, l2_req_instr, l2_req_data}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign cur_rw    = cur[REQ_W-1];
    assign cur_instr = cur[DATA_WIDTH +: L2_REQ_WIDTH];
    assign cur_data  = cur[DATA_WIDTH-1:0];
    assign bank_id   = cur_instr[BANK_MSB:BANK_LSB];
    assign row_id    = cur_instr[ROW_MSB:ROW_LSB];
    assign col_id    = cur_instr[COL_MSB:COL_LSB];
    assign bit_idx   = BIT_W'(DATA_WIDTH-1) - access_count;
    assign col_idx   = col_id + bit_idx;

    assign dram_data = buf_rw ? cur_data[bit_idx] : 1'bz;

    assign dbg = '{state: state_q, refresh_flag: refresh_flag, fifo_count: fifo_count,
                   offset: cur_instr[OFS_MSB:OFS_LSB]};

    always_ff @(posedge clk) begin
        if (rst_b) begin
            refresh_cnt  <= '0;
            refresh_flag <= 1'b0;
        end else begin
            if (refresh_cnt == CNT_W'(REFRESH_INTERVAL-1)) begin
                refresh_cnt  <= '0;
                refresh_flag <= 1'b1;
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
                if (ref_done) refresh_flag <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q      <= ST_IDLE;
            prev_key     <= '0;
            first_q      <= 1'b1;
            cur          <= '0;
            access_count <= '0;
            l2_rsp_data  <= '0;
        end else begin
            state_q  <= state_d;
            prev_key <= {l2_rw_req, l2_req_instr};
            first_q  <= 1'b0;
            if (fifo_pop) cur <= head;
            if (state_q == ST_ACT) begin
                access_count <= BIT_W'(DATA_WIDTH-1);
            end else if (state_q == ST_XFER_REL && !cmd_ack && access_count != '0) begin
                access_count <= access_count - 1'b1;
            end
            if (state_q == ST_XFER && !cur_rw && cmd_ack) begin
                l2_rsp_data[bit_idx] <= dram_data;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cmd_req  = 1'b0;
        cmd      = CMD_ACT;
        bank_sel = '0;
        row_sel  = '0;
        col_sel  = '0;
        bank_rw  = 1'b0;
        buf_rw   = 1'b0;
        fifo_pop = 1'b0;
        ref_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A stale ack from an interrupted handshake must clear before anything new starts.
                if (!cmd_ack) begin
                    if (refresh_flag) begin
                        state_d = ST_REF;
                    end else if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        state_d  = ST_ACT;
                    end
                end
            end
            ST_ACT: begin
                cmd_req  = 1'b1;
                cmd      = CMD_ACT;
                bank_sel = NUM_OF_BANKS'(1) << bank_id;
                row_sel  = NUM_OF_ROWS'(1) << row_id;
                if (cmd_ack) state_d = ST_ACT_REL;
            end
            ST_ACT_REL: begin
                if (!cmd_ack) state_d = ST_XFER;
            end
            ST_XFER: begin
                cmd_req  = 1'b1;
                cmd      = cur_rw ? CMD_WRITE : CMD_READ;
                bank_sel = NUM_OF_BANKS'(1) << bank_id;
                row_sel  = NUM_OF_ROWS'(1) << row_id;
                col_sel  = NUM_OF_COLS'(1) << col_idx;
                bank_rw  = cur_rw;
                buf_rw   = cur_rw;
                if (cmd_ack) state_d = ST_XFER_REL;
            end
            ST_XFER_REL: begin
                if (!cmd_ack) state_d = (access_count == '0) ? ST_IDLE : ST_XFER;
            end
            ST_REF: begin
                cmd_req  = 1'b1;
                cmd      = CMD_REF;
                bank_sel = '1;
                if (cmd_ack) state_d = ST_REF_REL;
            end
            ST_REF_REL: begin
                if (!cmd_ack) begin
                    ref_done = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_dram_controller.sv
// Directed + randomized bench: a bit-serial DRAM responder plus a request-level reference
// model that predicts the full command stream and read data.
module tb_dram_controller;
    import dram_ctrl_pkg::*;

    localparam int CW = 2 + 8 + 128 + 8 + 3;

    logic         clk = 1'b0;
    logic         rst_b;
    logic         l2_rw_req;
    logic [19:0]  l2_req_instr;
    logic [7:0]   l2_req_data;
    logic         cmd_ack;
    logic         cmd_req;
    logic [1:0]   cmd;
    logic [7:0]   bank_sel;
    logic [127:0] row_sel;
    logic [7:0]   col_sel;
    logic         bank_rw;
    logic         buf_rw;
    wire          dram_data;
    logic [7:0]   l2_rsp_data;
    dbg_t         dbg;

    logic         drv_en;
    logic         drv_val;
    assign dram_data = drv_en ? drv_val : 1'bz;

    dram_controller dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .l2_rw_req    (l2_rw_req),
        .l2_req_instr (l2_req_instr),
        .l2_req_data  (l2_req_data),
        .cmd_ack      (cmd_ack),
        .cmd_req      (cmd_req),
        .cmd          (cmd),
        .bank_sel     (bank_sel),
        .row_sel      (row_sel),
        .col_sel      (col_sel),
        .bank_rw      (bank_rw),
        .buf_rw       (buf_rw),
        .dram_data    (dram_data),
        .l2_rsp_data  (l2_rsp_data),
        .dbg          (dbg)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // scoreboard state
    logic [CW-1:0] exp_q[$];
    logic [7:0]    model_mem [0:1023];
    logic [7:0]    dram_mem  [0:1023];
    logic [7:0]    exp_rsp;
    logic [20:0]   last_key;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            n_ref = 0;
    int            n_wr  = 0;
    bit            stall = 1'b0;

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int oh_idx(input logic [127:0] v);
        for (int i = 0; i < 128; i++) if (v[i]) return i;
        return 0;
    endfunction

    // Reference: one ACT then DATA_WIDTH bit accesses, bit i at column (col+i) mod 8.
    function automatic void model_request(input logic rw, input logic [19:0] instr, input logic [7:0] data);
        logic [2:0]   b;
        logic [6:0]   r;
        logic [2:0]   c;
        logic [2:0]   col;
        logic [7:0]   bs;
        logic [127:0] rs;
        b  = instr[12:10];
        r  = instr[9:3];
        c  = instr[2:0];
        bs = 8'b1 << b;
        rs = 128'b1 << r;
        exp_q.push_back({CMD_ACT, bs, rs, 8'b0, 3'b000});
        for (int i = 0; i < 8; i++) begin
            col = 3'((int'(c) + i) % 8);
            if (rw) begin
                exp_q.push_back({CMD_WRITE, bs, rs, 8'b1 << col, 2'b11, data[i]});
                model_mem[{b, r}][col] = data[i];
            end else begin
                exp_q.push_back({CMD_READ, bs, rs, 8'b1 << col, 3'b000});
                exp_rsp[i] = model_mem[{b, r}][col];
            end
        end
    endfunction

    // driver: apply one input tuple at a negedge; model decides if it is a new request
    task automatic send(input logic rw, input logic [19:0] instr, input logic [7:0] data, input bit accept);
        l2_rw_req    = rw;
        l2_req_instr = instr;
        l2_req_data  = data;
        if ({rw, instr} != last_key && accept) model_request(rw, instr, data);
        last_key = {rw, instr};
    endtask

    task automatic wait_done(input int budget, input string tag);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            done = (exp_q.size() == 0) && (dbg.state == ST_IDLE) && !cmd_req && !cmd_ack
                   && (dbg.fifo_count == '0);
        end
        check(tag, CW'(done), CW'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_req"}, CW'(cmd_req), CW'(0));
        check({tag, "_cmd"}, CW'(cmd), CW'(0));
        check({tag, "_sels"}, CW'({bank_sel, row_sel, col_sel}), CW'(0));
        check({tag, "_rw"}, CW'({bank_rw, buf_rw}), CW'(0));
        check({tag, "_dram_data"}, CW'(dram_data), CW'(1'bz));
        check({tag, "_rsp"}, CW'(l2_rsp_data), CW'(0));
        check({tag, "_fifo"}, CW'(dbg.fifo_count), CW'(0));
    endtask

    // DRAM responder: random ack latency, stores writes, drives read bits
    initial begin
        logic [CW-1:0] obs;
        logic [9:0]    a;
        int            ci;
        cmd_ack = 1'b0;
        drv_en  = 1'b0;
        drv_val = 1'b0;
        forever begin
            @(negedge clk);
            if (cmd_req && !cmd_ack) begin
                if (!stall && $urandom_range(0, 2) != 0) begin
                    obs = {cmd, bank_sel, row_sel, col_sel, bank_rw, buf_rw, buf_rw ? dram_data : 1'b0};
                    a   = {3'(oh_idx(128'(bank_sel))), 7'(oh_idx(row_sel))};
                    ci  = oh_idx(128'(col_sel));
                    if (cmd == CMD_REF) begin
                        n_ref++;
                        check("refresh_cmd", obs, {CMD_REF, 8'hFF, 128'b0, 8'b0, 3'b000});
                    end else begin
                        check("cmd_expected", CW'(exp_q.size() != 0), CW'(1));
                        if (exp_q.size() != 0) check("cmd_stream", obs, exp_q.pop_front());
                        if (cmd == CMD_WRITE) begin
                            dram_mem[a][ci] = dram_data;
                            n_wr++;
                        end else if (cmd == CMD_READ) begin
                            drv_val = dram_mem[a][ci];
                            drv_en  = 1'b1;
                        end
                    end
                    cmd_ack = 1'b1;
                end
            end else if (!cmd_req && cmd_ack) begin
                if ($urandom_range(0, 1) == 0) begin
                    cmd_ack = 1'b0;
                    drv_en  = 1'b0;
                end
            end
        end
    end

    // directed sequence
    initial begin
        logic        rw;
        logic [19:0] instr;
        logic [7:0]  old_byte;
        logic [2:0]  col;
        int          r0;
        int          max_cnt;
        bit          seen;

        for (int i = 0; i < 1024; i++) begin
            model_mem[i] = 8'h00;
            dram_mem[i]  = 8'h00;
        end
        exp_rsp      = 8'h00;
        rst_b        = 1'b1;
        l2_rw_req    = 1'b0;
        l2_req_instr = 20'h0;
        l2_req_data  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        check("reset_refresh_flag", CW'(dbg.refresh_flag), CW'(0));

        // first cycle out of reset counts as a new request (read of bank0/row0/col0)
        rst_b    = 1'b0;
        last_key = 21'h0;
        model_request(1'b0, 20'h0, 8'h00);

        repeat (511) @(posedge clk);
        @(negedge clk);
        check("refresh_flag_before_interval", CW'(dbg.refresh_flag), CW'(0));
        @(posedge clk);
        @(negedge clk);
        check("refresh_flag_at_interval", CW'(dbg.refresh_flag), CW'(1));
        r0   = n_ref;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = (n_ref != r0) && (dbg.state == ST_IDLE);
        end
        check("refresh_serviced", CW'(seen), CW'(1));
        check("refresh_flag_cleared", CW'(dbg.refresh_flag), CW'(0));
        check("refresh_count", CW'(n_ref - r0), CW'(1));
        check("first_read_rsp", CW'(l2_rsp_data), CW'(exp_rsp));

        // single write bank3/row5/col2 data 0xA5, then read back
        send(1'b1, {7'd0, 3'd3, 7'd5, 3'd2}, 8'hA5, 1'b1);
        wait_done(400, "write_a5_done");
        check("write_a5_cells", CW'(dram_mem[{3'd3, 7'd5}]), CW'(8'h96));
        send(1'b0, {7'd0, 3'd3, 7'd5, 3'd2}, 8'h00, 1'b1);
        wait_done(400, "read_a5_done");
        check("read_a5_rsp", CW'(l2_rsp_data), CW'(8'hA5));

        // same address/direction with different data is not a new request
        send(1'b0, {7'd0, 3'd3, 7'd5, 3'd2}, 8'h3C, 1'b1);
        repeat (40) @(negedge clk);
        check("repeat_not_queued", CW'({exp_q.size() != 0, cmd_req, dbg.fifo_count}), CW'(0));

        // randomized single requests over a small address window
        for (int k = 0; k < 24; k++) begin
            rw    = 1'($urandom_range(0, 1));
            instr = {7'($urandom), 3'($urandom_range(0, 1)), 7'($urandom_range(0, 3)), 3'($urandom)};
            if ({rw, instr} == last_key) instr[19] = ~instr[19];
            send(rw, instr, 8'($urandom), 1'b1);
            wait_done(400, "rand_done");
            if (!rw) check("rand_rsp", CW'(l2_rsp_data), CW'(exp_rsp));
        end

        // overflow: freeze the DRAM during R0's ACT, then burst 32 distinct writes
        r0   = n_ref;
        seen = 1'b0;
        for (int i = 0; i < 700 && !seen; i++) begin
            @(negedge clk);
            seen = (n_ref != r0) && (dbg.state == ST_IDLE) && !cmd_ack;
        end
        check("pre_overflow_refresh", CW'(seen), CW'(1));
        stall = 1'b1;
        send(1'b1, {7'd0, 3'd7, 7'd100, 3'd4}, 8'($urandom), 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = cmd_req;
        end
        check("overflow_r0_act", CW'({seen, cmd}), CW'({1'b1, CMD_ACT}));
        max_cnt = 0;
        for (int k = 0; k < 32; k++) begin
            send(1'b1, {7'd0, 3'(k), 7'(20 + k), 3'(k)}, 8'($urandom), k < 16);
            @(negedge clk);
            if (int'(dbg.fifo_count) > max_cnt) max_cnt = int'(dbg.fifo_count);
        end
        repeat (4) @(negedge clk);
        if (int'(dbg.fifo_count) > max_cnt) max_cnt = int'(dbg.fifo_count);
        check("overflow_fifo_max", CW'(max_cnt), CW'(16));
        stall = 1'b0;
        wait_done(4000, "overflow_done");

        // reset after three write bits of a request
        instr    = {7'd9, 3'd6, 7'd9, 3'd5};
        old_byte = model_mem[{3'd6, 7'd9}];
        n_wr     = 0;
        send(1'b1, instr, 8'($urandom), 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = (n_wr >= 3);
        end
        check("reset_mid_reached", CW'(seen), CW'(1));
        rst_b     = 1'b1;
        l2_rw_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("mid_reset");
        exp_q.delete();
        for (int i = 3; i < 8; i++) begin
            col = 3'((5 + i) % 8);
            model_mem[{3'd6, 7'd9}][col] = old_byte[col];
        end
        @(posedge clk);
        @(negedge clk);
        check("mid_reset_hold_idle", CW'(cmd_req), CW'(0));
        rst_b    = 1'b0;
        last_key = {1'b0, instr};
        model_request(1'b0, instr, 8'h00);
        wait_done(400, "post_reset_read_done");
        check("post_reset_bits_written", CW'(n_wr), CW'(3));
        check("post_reset_rsp", CW'(l2_rsp_data), CW'(exp_rsp));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
